// File: rtl/counter_sequencer.sv
// Burst sequencer for the loadable up-counter: one-cycle preset load, a timed
// write_now burst, an idle gap, optional repetition. Every output is registered.
module counter_sequencer #(
  parameter int WIDTH     = 8,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  input  logic                 in_start,
  input  logic                 in_abort,
  input  logic [WIDTH-1:0]     in_cfg_load_value,
  input  logic [LEN_WIDTH-1:0] in_cfg_length,
  input  logic [LEN_WIDTH-1:0] in_cfg_gap,
  input  logic                 in_cfg_repeat,
  output logic [WIDTH-1:0]     out_load_value,
  output logic                 out_load_now,
  output logic                 out_write_now,
  output logic                 out_busy,
  output logic                 out_done,
  output logic [LEN_WIDTH-1:0] out_remaining
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRIVE,
    S_GAP,
    S_DONE
  } state_t;

  state_t               state, state_n;
  logic [LEN_WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0]     sh_val, sh_val_n;
  logic [LEN_WIDTH-1:0] sh_len, sh_len_n;
  logic [LEN_WIDTH-1:0] sh_gap, sh_gap_n;
  logic                 sh_rep, sh_rep_n;

  logic [WIDTH-1:0]     load_value_n;
  logic [LEN_WIDTH-1:0] remaining_n;

  // cnt holds the cycles left in the current DRIVE or GAP phase; phases are
  // only entered with a nonzero count, so the decrement never wraps.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sh_val_n = sh_val;
    sh_len_n = sh_len;
    sh_gap_n = sh_gap;
    sh_rep_n = sh_rep;

    case (state)
      S_IDLE, S_DONE: begin
        if (in_start && !in_abort) begin
          sh_val_n = in_cfg_load_value;
          sh_len_n = in_cfg_length;
          sh_gap_n = in_cfg_gap;
          sh_rep_n = in_cfg_repeat;
          state_n  = S_LOAD;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_LOAD: begin
        if (in_abort) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (sh_len != '0) begin
          state_n = S_DRIVE;
          cnt_n   = sh_len;
        end else if (sh_gap != '0) begin
          state_n = S_GAP;
          cnt_n   = sh_gap;
        end else begin
          state_n = sh_rep ? S_LOAD : S_DONE;
        end
      end
      S_DRIVE: begin
        if (in_abort) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (cnt != LEN_WIDTH'(1)) begin
          cnt_n = cnt - LEN_WIDTH'(1);
        end else if (sh_gap != '0) begin
          state_n = S_GAP;
          cnt_n   = sh_gap;
        end else begin
          state_n = sh_rep ? S_LOAD : S_DONE;
          cnt_n   = '0;
        end
      end
      S_GAP: begin
        if (in_abort) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (cnt != LEN_WIDTH'(1)) begin
          cnt_n = cnt - LEN_WIDTH'(1);
        end else begin
          state_n = sh_rep ? S_LOAD : S_DONE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase

    // Outputs are registered copies of what the next state implies.
    load_value_n = (state_n == S_LOAD) ? sh_val_n : out_load_value;
    remaining_n  = (state_n == S_DRIVE) ? cnt_n : '0;
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      sh_val         <= '0;
      sh_len         <= '0;
      sh_gap         <= '0;
      sh_rep         <= 1'b0;
      out_load_value <= '0;
      out_load_now   <= 1'b0;
      out_write_now  <= 1'b0;
      out_busy       <= 1'b0;
      out_done       <= 1'b0;
      out_remaining  <= '0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      sh_val         <= sh_val_n;
      sh_len         <= sh_len_n;
      sh_gap         <= sh_gap_n;
      sh_rep         <= sh_rep_n;
      out_load_value <= load_value_n;
      out_load_now   <= (state_n == S_LOAD);
      out_write_now  <= (state_n == S_DRIVE);
      out_busy       <= (state_n == S_LOAD) || (state_n == S_DRIVE) || (state_n == S_GAP);
      out_done       <= (state_n == S_DONE);
      out_remaining  <= remaining_n;
    end
  end

endmodule
